// File: rtl/ins_loader.sv
// Byte-stream instruction loader: parses a length-prefixed, XOR-checksummed image
// and writes it word by word into instruction memory while holding the CPU.
module ins_loader #(
    parameter int WIDTH    = 32,
    parameter int MEM_SIZE = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    output logic                wr_en,
    output logic [MEM_SIZE-1:0] wr_addr,
    output logic [WIDTH-1:0]    wr_data,
    output logic                busy,
    output logic                cpu_hold,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] CAPACITY = 17'(1) << MEM_SIZE;

    state_t            state;
    logic [15:0]       len;
    logic [MEM_SIZE:0] word_cnt;
    logic [1:0]        byte_idx;
    logic [23:0]       asm_word;
    logic [7:0]        csum;

    logic        transfer;
    logic [16:0] len_full;
    logic [16:0] cnt_next;

    assign transfer = in_valid && in_ready;
    assign len_full = {1'b0, in_data, len[7:0]};
    assign cnt_next = 17'(word_cnt) + 17'd1;

    // NOTE: every register here is state, so all assignments are non-blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            len      <= '0;
            word_cnt <= '0;
            byte_idx <= '0;
            asm_word <= '0;
            csum     <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state    <= S_LEN_LO;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        word_cnt <= '0;
                        byte_idx <= '0;
                        csum     <= '0;
                    end
                end
                S_LEN_LO: begin
                    if (transfer) begin
                        len[7:0] <= in_data;
                        state    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (transfer) begin
                        len[15:8] <= in_data;
                        if (len_full == 17'd0) begin
                            state <= S_CHECK;
                        end else if (len_full > CAPACITY) begin
                            state    <= S_ERR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (transfer) begin
                        csum     <= csum ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx != 2'd3) begin
                            asm_word[8*byte_idx +: 8] <= in_data;
                        end else begin
                            // Write strobe lands the cycle after byte 3; the stream keeps flowing.
                            wr_en    <= 1'b1;
                            wr_addr  <= word_cnt[MEM_SIZE-1:0];
                            wr_data  <= WIDTH'({in_data, asm_word});
                            word_cnt <= word_cnt + 1'b1;
                            if (cnt_next == {1'b0, len}) begin
                                state <= S_CHECK;
                            end
                        end
                    end
                end
                S_CHECK: begin
                    if (transfer) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (in_data == csum) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ins_loader.sv
// Self-checking bench for ins_loader: directed and randomized image loads compared
// against an image-level model of expected writes and final status.
module tb_ins_loader;

    localparam int MEM_SIZE = 5;
    localparam int CAP      = 1 << MEM_SIZE;

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [31:0] word_q_t[$];

    logic                clk = 1'b0;
    logic                rst, start, in_valid;
    logic [7:0]          in_data;
    logic                in_ready, wr_en, busy, cpu_hold, done, err;
    logic [MEM_SIZE-1:0] wr_addr;
    logic [31:0]         wr_data;

    int total = 0;
    int bad   = 0;

    int          mon_addr[$];
    logic [31:0] mon_data[$];

    ins_loader #(.WIDTH(32), .MEM_SIZE(MEM_SIZE)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            mon_addr.push_back(int'(wr_addr));
            mon_data.push_back(wr_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_wr_en"},    64'(wr_en),    64'd0);
        check({tag, "_wr_addr"},  64'(wr_addr),  64'd0);
        check({tag, "_wr_data"},  64'(wr_data),  64'd0);
        check({tag, "_busy"},     64'(busy),     64'd0);
        check({tag, "_done"},     64'(done),     64'd0);
        check({tag, "_err"},      64'(err),      64'd0);
        check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
    endtask

    // Starts a load with the first stream byte already valid, so a loader that
    // consumed bytes in IDLE would misparse the image.
    task automatic pulse_start(input logic [7:0] first);
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = first;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: contiguous, 1: valid every other cycle, 2: random gaps plus stray starts
    task automatic drive_stream(input byte_q_t s, input int mode, input string tag);
        int idx = 0;
        int cyc = 0;
        int budget = 8 * s.size() + 40;
        bit v, acc;
        pulse_start(s[0]);
        check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
        while (busy && cyc < budget) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 0;
                default: v = $urandom_range(0, 2) != 0;
            endcase
            if (idx >= s.size()) v = 1'b0;
            in_valid = v;
            in_data  = v ? s[idx] : 8'($urandom);
            start    = (mode == 2) && ($urandom_range(0, 7) == 0);
            acc      = v && in_ready;
            @(posedge clk);
            if (acc) idx++;
            @(negedge clk);
            cyc++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check({tag, "_finished_in_budget"}, 64'(cyc < budget), 64'd1);
    endtask

    // Reference: an image of n words lands at addresses 0..n-1 unless n exceeds
    // capacity; success requires the checksum byte to equal the payload XOR.
    task automatic run_test(input string tag, input int n, input word_q_t words,
                            input bit corrupt, input int mode);
        byte_q_t     s;
        logic [7:0]  x = 8'h00;
        logic [7:0]  chk;
        bit          exp_err;
        int          exp_writes;
        mon_addr.delete();
        mon_data.delete();
        s.push_back(8'(n));
        s.push_back(8'(n >> 8));
        if (n <= CAP) begin
            foreach (words[i]) begin
                for (int b = 0; b < 4; b++) begin
                    s.push_back(words[i][8*b +: 8]);
                    x ^= words[i][8*b +: 8];
                end
            end
            chk = corrupt ? (x ^ 8'(1 << $urandom_range(0, 7))) : x;
            s.push_back(chk);
        end
        exp_err    = (n > CAP) || corrupt;
        exp_writes = (n > CAP) ? 0 : n;
        drive_stream(s, mode, tag);
        // Trailing bytes after the load finishes must be refused.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(negedge clk);
            check({tag, "_in_ready_after"}, 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        check({tag, "_write_count"}, 64'(mon_addr.size()), 64'(exp_writes));
        for (int i = 0; i < exp_writes; i++) begin
            if (i < mon_addr.size()) begin
                check($sformatf("%s_wr%0d_addr", tag, i), 64'(mon_addr[i]), 64'(i));
                check($sformatf("%s_wr%0d_data", tag, i), 64'(mon_data[i]), 64'(words[i]));
            end
        end
        check({tag, "_done"},     64'(done),     64'(!exp_err));
        check({tag, "_err"},      64'(err),      64'(exp_err));
        check({tag, "_busy"},     64'(busy),     64'd0);
        check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'(exp_err));
        check({tag, "_wr_en"},    64'(wr_en),    64'd0);
    endtask

    initial begin
        word_q_t w;
        rst      = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_reset_values("idle");

        // Single word; the checksum byte is derived from the payload bytes.
        w = '{32'h00A00513};
        run_test("one_word", 1, w, 1'b0, 0);

        w = '{32'h00000093, 32'h00100113};
        run_test("two_words_toggle", 2, w, 1'b0, 1);

        w = '{32'h00A00513};
        run_test("bad_checksum", 1, w, 1'b1, 0);

        w = {};
        run_test("too_long", CAP + 1, w, 1'b0, 0);
        run_test("empty_ok", 0, w, 1'b0, 0);
        run_test("empty_bad", 0, w, 1'b1, 0);

        w = {};
        for (int i = 0; i < CAP; i++) w.push_back($urandom);
        run_test("full_capacity", CAP, w, 1'b0, 2);

        // Reset right after the fourth payload byte of word 0 is accepted.
        begin
            logic [7:0] pre[6] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
            pulse_start(pre[0]);
            for (int i = 0; i < 6; i++) begin
                in_valid = 1'b1;
                in_data  = pre[i];
                @(negedge clk);
            end
            in_valid = 1'b1;
            start    = 1'b1;
            rst      = 1'b1;
            @(negedge clk);
            check_reset_values("mid_rst");
            rst      = 1'b0;
            start    = 1'b0;
            in_valid = 1'b0;
            @(negedge clk);
        end
        w = '{32'hDEADBEEF, 32'h12345678, 32'h0000006F};
        run_test("after_rst", 3, w, 1'b0, 0);

        for (int t = 0; t < 6; t++) begin
            int n = $urandom_range(1, 8);
            w = {};
            for (int i = 0; i < n; i++) w.push_back($urandom);
            run_test($sformatf("rand%0d", t), n, w, $urandom_range(0, 2) == 0, 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
